fft_spectrum_writer: RTL and testbench

FFT_SPECTRUM_WRITER -- requirements
Module: fft_spectrum_writer

---
 rtl/fft_spectrum_writer.sv | 192 +++++++++++++++++++
 tb/tb_fft_spectrum_writer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_spectrum_writer.sv
// ---------------------------------------------------------------------------
// fft_spectrum_writer
//   Turns a streamed complex FFT frame into magnitude-squared bins and writes
//   them into one half of a ping-pong spectrum RAM. A finished frame is
//   published to the display side by flipping rd_bank, unless the display
//   still holds an unacknowledged frame. In that case the new frame is
//   dropped and counted, and its bank is overwritten by the next frame.
//
// Ports
//   fft_clk        single clock, rising edge
//   rst_n          synchronous active-low reset
//   fft_data_in    {re[15:0], im[15:0]}, both signed
//   fft_data_valid fft_data_in valid this cycle
//   fft_data_last  final sample of a frame (qualified by fft_data_valid)
//   frame_ack      display-side pulse releasing the published bank
//   wr_addr        {bank, bin[7:0]} RAM write address
//   wr_data        unsigned magnitude-squared, clamped to SAT_MAX
//   wr_en          RAM write strobe
//   rd_bank        bank owned by the display side
//   frame_ready    rd_bank holds a complete, unacknowledged frame
//   frame_len      number of bins in the published frame
//   overflow_cnt   completed frames dropped, saturating at 255
// ---------------------------------------------------------------------------
module fft_spectrum_writer #(
    parameter int unsigned N_BINS  = 256,
    parameter logic [31:0] SAT_MAX = 32'hFFFF_FFFF
) (
    input  logic        fft_clk,
    input  logic        rst_n,
    input  logic [31:0] fft_data_in,
    input  logic        fft_data_valid,
    input  logic        fft_data_last,
    input  logic        frame_ack,
    output logic [8:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        wr_en,
    output logic        rd_bank,
    output logic        frame_ready,
    output logic [8:0]  frame_len,
    output logic [7:0]  overflow_cnt
);

    localparam int unsigned CNT_W       = 9;
    localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(N_BINS - 1);
    localparam logic [32:0] SAT_MAX_EXT = {1'b0, SAT_MAX};

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SKIP,
        DRAIN,
        PUBLISH
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  bin_idx;     // samples accepted so far in this frame
    logic              drain_cnt;

    // Stage-1 pipeline registers
    logic              s1_valid;
    logic [8:0]        s1_addr;
    logic [31:0]       s1_re2;
    logic [31:0]       s1_im2;

    logic signed [15:0] re_c;
    logic signed [15:0] im_c;
    logic signed [31:0] re_sq_c;
    logic signed [31:0] im_sq_c;
    logic [32:0]        sum_c;
    logic               accept_c;

    assign re_c = fft_data_in[31:16];
    assign im_c = fft_data_in[15:0];

    // Squares are never negative and (-32768)^2 = 2^30 fits, so the signed
    // 32-bit product can be reinterpreted as unsigned without loss.
    assign re_sq_c = 32'(re_c) * 32'(re_c);
    assign im_sq_c = 32'(im_c) * 32'(im_c);

    // One extra bit so the worst case 2^31 + carry never wraps.
    assign sum_c = 33'(s1_re2) + 33'(s1_im2);

    // Only IDLE and CAPTURE produce writes; SKIP/DRAIN/PUBLISH drop samples.
    assign accept_c = fft_data_valid && ((state == IDLE) || (state == CAPTURE));

    // Two-stage magnitude pipeline: square, then add and clamp.
    always_ff @(posedge fft_clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_re2   <= '0;
            s1_im2   <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                // Write bank is the one the display is not reading.
                s1_addr <= {~rd_bank, bin_idx[7:0]};
                s1_re2  <= $unsigned(re_sq_c);
                s1_im2  <= $unsigned(im_sq_c);
            end
            wr_en <= s1_valid;
            if (s1_valid) begin
                wr_addr <= s1_addr;
                wr_data <= (sum_c > SAT_MAX_EXT) ? SAT_MAX : sum_c[31:0];
            end
        end
    end

    // Frame sequencing and bank handoff.
    always_ff @(posedge fft_clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            bin_idx      <= '0;
            drain_cnt    <= 1'b0;
            rd_bank      <= 1'b0;
            frame_ready  <= 1'b0;
            frame_len    <= '0;
            overflow_cnt <= '0;
        end else begin
            // Ack releases the current frame; a same-cycle publish below
            // overrides this with the new frame.
            if (frame_ack && frame_ready) begin
                frame_ready <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (fft_data_valid) begin
                        bin_idx <= CNT_W'(1);
                        if (fft_data_last) begin
                            state     <= DRAIN;
                            drain_cnt <= 1'b0;
                        end else if (LAST_BIN == '0) begin
                            state <= SKIP;
                        end else begin
                            state <= CAPTURE;
                        end
                    end
                end

                CAPTURE: begin
                    if (fft_data_valid) begin
                        bin_idx <= bin_idx + CNT_W'(1);
                        if (fft_data_last) begin
                            state     <= DRAIN;
                            drain_cnt <= 1'b0;
                        end else if (bin_idx == LAST_BIN) begin
                            state <= SKIP;
                        end
                    end
                end

                // Frame already full; wait for the producer's last marker.
                SKIP: begin
                    if (fft_data_valid && fft_data_last) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end

                // Two cycles let the last sample leave the pipeline.
                DRAIN: begin
                    if (drain_cnt) begin
                        state <= PUBLISH;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end

                PUBLISH: begin
                    state   <= IDLE;
                    bin_idx <= '0;
                    if (!frame_ready || frame_ack) begin
                        rd_bank     <= ~rd_bank;
                        frame_ready <= 1'b1;
                        frame_len   <= bin_idx;
                    end else if (overflow_cnt != 8'hFF) begin
                        overflow_cnt <= overflow_cnt + 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_spectrum_writer.sv
// ---------------------------------------------------------------------------
// tb_fft_spectrum_writer
//   Directed bench for fft_spectrum_writer. A second instance with a lowered
//   SAT_MAX shares the stimulus so the clamp path can be observed.
// ---------------------------------------------------------------------------
module tb_fft_spectrum_writer;

    logic        fft_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fft_data_in = '0;
    logic        fft_data_valid = 1'b0;
    logic        fft_data_last = 1'b0;
    logic        frame_ack = 1'b0;

    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        rd_bank;
    logic        frame_ready;
    logic [8:0]  frame_len;
    logic [7:0]  overflow_cnt;

    logic [8:0]  s_wr_addr;
    logic [31:0] s_wr_data;
    logic        s_wr_en;
    logic        s_rd_bank;
    logic        s_frame_ready;
    logic [8:0]  s_frame_len;
    logic [7:0]  s_overflow_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    logic [8:0]  wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];
    logic [31:0] sq_data[$];

    fft_spectrum_writer dut (
        .fft_clk        (fft_clk),
        .rst_n          (rst_n),
        .fft_data_in    (fft_data_in),
        .fft_data_valid (fft_data_valid),
        .fft_data_last  (fft_data_last),
        .frame_ack      (frame_ack),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .rd_bank        (rd_bank),
        .frame_ready    (frame_ready),
        .frame_len      (frame_len),
        .overflow_cnt   (overflow_cnt)
    );

    fft_spectrum_writer #(.N_BINS(256), .SAT_MAX(32'h0FFF_FFFF)) sat_dut (
        .fft_clk        (fft_clk),
        .rst_n          (rst_n),
        .fft_data_in    (fft_data_in),
        .fft_data_valid (fft_data_valid),
        .fft_data_last  (fft_data_last),
        .frame_ack      (frame_ack),
        .wr_addr        (s_wr_addr),
        .wr_data        (s_wr_data),
        .wr_en          (s_wr_en),
        .rd_bank        (s_rd_bank),
        .frame_ready    (s_frame_ready),
        .frame_len      (s_frame_len),
        .overflow_cnt   (s_overflow_cnt)
    );

    always #5 fft_clk = ~fft_clk;

    always @(posedge fft_clk) cyc <= cyc + 1;

    // Record every RAM write, sampled mid-cycle.
    always @(negedge fft_clk) begin
        if (wr_en === 1'b1) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
            wq_cyc.push_back(cyc);
        end
        if (s_wr_en === 1'b1) begin
            sq_data.push_back(s_wr_data);
        end
    end

    task automatic tick();
        @(posedge fft_clk);
        #1;
    endtask

    task automatic clear_q();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        sq_data.delete();
    endtask

    function automatic logic [15:0] re_of(input int mode, input int i);
        case (mode)
            0:       return 16'd3;
            1:       return 16'hFFFB;
            2:       return 16'(i - 150);
            default: return 16'h8000;
        endcase
    endfunction

    function automatic logic [15:0] im_of(input int mode);
        case (mode)
            0:       return 16'd4;
            1:       return 16'd7;
            2:       return 16'd2;
            default: return 16'h8000;
        endcase
    endfunction

    // Reference |x|^2 from the sample generators, unclamped.
    function automatic logic [31:0] exp_mag(input int mode, input int i);
        logic signed [15:0] r;
        logic signed [15:0] m;
        longint s;
        r = re_of(mode, i);
        m = im_of(mode);
        s = longint'(r) * longint'(r) + longint'(m) * longint'(m);
        return 32'(s);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Drive n samples; with_last marks the final one, gaps inserts idle cycles.
    task automatic send_frame(input int n, input int mode, input bit gaps,
                              input bit with_last, output int first_cyc);
        first_cyc = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                fft_data_valid = 1'b0;
                fft_data_last  = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            if (i == 0) first_cyc = cyc;
            fft_data_in    = {re_of(mode, i), im_of(mode)};
            fft_data_valid = 1'b1;
            fft_data_last  = with_last && (i == n - 1);
            tick();
        end
        fft_data_valid = 1'b0;
        fft_data_last  = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (frame_ready !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        total_cnt++;
        if (frame_ready !== 1'b1) begin
            $display("FAIL %s: frame_ready not seen within 20 cycles", name);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic check_writes(input string name, input int n, input logic bank, input int mode);
        int err;
        chk({name, "_count"}, 32'(wq_addr.size()), 32'(n));
        err = 0;
        for (int i = 0; i < n && i < wq_addr.size(); i++) begin
            if (wq_addr[i] !== {bank, 8'(i)} || wq_data[i] !== exp_mag(mode, i)) begin
                if (err == 0) begin
                    $display("FAIL %s_entry%0d: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             name, i, wq_addr[i], wq_data[i], {bank, 8'(i)}, exp_mag(mode, i));
                end
                err++;
            end
        end
        chk({name, "_bad_entries"}, 32'(err), 32'd0);
    endtask

    task automatic pulse_ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fft_data_valid = 1'b0;
        fft_data_last = 1'b0;
        frame_ack = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clear_q();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_rd_bank", 32'(rd_bank), 32'd0);
        chk("rst_frame_ready", 32'(frame_ready), 32'd0);
        chk("rst_frame_len", 32'(frame_len), 32'd0);
        chk("rst_overflow_cnt", 32'(overflow_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        clear_q();
    endtask

    task automatic test_full_frame();
        int first;
        send_frame(256, 0, 1'b0, 1'b1, first);
        wait_ready("full_ready");
        check_writes("full", 256, 1'b1, 0);
        chk("full_latency", 32'((wq_cyc.size() > 0) ? wq_cyc[0] - first : -1), 32'd2);
        chk("full_rd_bank", 32'(rd_bank), 32'd1);
        chk("full_frame_len", 32'(frame_len), 32'd256);
        pulse_ack();
        chk("full_ack_clears", 32'(frame_ready), 32'd0);
        chk("full_ack_keeps_bank", 32'(rd_bank), 32'd1);
        clear_q();
    endtask

    task automatic test_gaps();
        int first;
        send_frame(100, 1, 1'b1, 1'b1, first);
        wait_ready("gaps_ready");
        check_writes("gaps", 100, 1'b0, 1);
        chk("gaps_frame_len", 32'(frame_len), 32'd100);
        chk("gaps_rd_bank", 32'(rd_bank), 32'd0);
        pulse_ack();
        clear_q();
    endtask

    task automatic test_long_frame();
        int first;
        send_frame(300, 2, 1'b0, 1'b1, first);
        wait_ready("long_ready");
        repeat (4) tick();
        check_writes("long", 256, 1'b1, 2);
        chk("long_frame_len", 32'(frame_len), 32'd256);
        chk("long_rd_bank", 32'(rd_bank), 32'd1);
        chk("long_one_publish", 32'(overflow_cnt), 32'd0);
        pulse_ack();
        clear_q();
    endtask

    task automatic test_back_to_back();
        int first;
        do_reset();
        send_frame(10, 0, 1'b0, 1'b1, first);
        wait_ready("b2b_first_ready");
        chk("b2b_first_len", 32'(frame_len), 32'd10);
        clear_q();
        send_frame(20, 1, 1'b0, 1'b1, first);
        repeat (8) tick();
        check_writes("b2b_second", 20, 1'b0, 1);
        chk("b2b_rd_bank", 32'(rd_bank), 32'd1);
        chk("b2b_overflow", 32'(overflow_cnt), 32'd1);
        chk("b2b_len_kept", 32'(frame_len), 32'd10);
        chk("b2b_still_ready", 32'(frame_ready), 32'd1);
        // Ack lands exactly in the PUBLISH cycle of the next frame.
        clear_q();
        send_frame(5, 0, 1'b0, 1'b1, first);
        repeat (2) tick();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("ackpub_ready", 32'(frame_ready), 32'd1);
        chk("ackpub_rd_bank", 32'(rd_bank), 32'd0);
        chk("ackpub_overflow", 32'(overflow_cnt), 32'd1);
        chk("ackpub_len", 32'(frame_len), 32'd5);
        check_writes("ackpub", 5, 1'b0, 0);
        pulse_ack();
        chk("ack_clear", 32'(frame_ready), 32'd0);
        pulse_ack();
        chk("ack_idle_ready", 32'(frame_ready), 32'd0);
        chk("ack_idle_bank", 32'(rd_bank), 32'd0);
        chk("ack_idle_overflow", 32'(overflow_cnt), 32'd1);
        clear_q();
    endtask

    task automatic test_saturation();
        int first;
        do_reset();
        send_frame(1, 3, 1'b0, 1'b1, first);
        wait_ready("sat_ready");
        chk("sat_count", 32'(wq_data.size()), 32'd1);
        chk("sat_nowrap", (wq_data.size() > 0) ? wq_data[0] : 32'hDEAD_BEEF, 32'h8000_0000);
        chk("sat_addr", (wq_addr.size() > 0) ? 32'(wq_addr[0]) : 32'hDEAD_BEEF, 32'h100);
        chk("sat_clamped", (sq_data.size() > 0) ? sq_data[0] : 32'hDEAD_BEEF, 32'h0FFF_FFFF);
        chk("sat_frame_len", 32'(frame_len), 32'd1);
        clear_q();
    endtask

    task automatic test_reset_mid_frame();
        int first;
        do_reset();
        send_frame(50, 0, 1'b0, 1'b0, first);
        fft_data_in    = {re_of(0, 50), im_of(0)};
        fft_data_valid = 1'b1;
        rst_n          = 1'b0;
        tick();
        chk("midrst_no_write", 32'(wr_en), 32'd0);
        fft_data_valid = 1'b0;
        rst_n          = 1'b1;
        repeat (6) tick();
        chk("midrst_no_publish", 32'(frame_ready), 32'd0);
        clear_q();
        send_frame(256, 0, 1'b0, 1'b1, first);
        wait_ready("midrst_ready");
        check_writes("midrst", 256, 1'b1, 0);
        chk("midrst_rd_bank", 32'(rd_bank), 32'd1);
        chk("midrst_overflow", 32'(overflow_cnt), 32'd0);
        chk("midrst_len", 32'(frame_len), 32'd256);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gaps();
        test_long_frame();
        test_back_to_back();
        test_saturation();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
